// File: rtl/mano_pkg.sv
// ---------------------------------------------------------------------------
// mano_pkg
// Shared constants and types for the Mano basic computer address-register
// slice.
//   D_AND..D_RR : bit positions in the one-hot opcode decode D[7:0]
//   T0..T7      : bit positions in the one-hot timing vector T
//   ar_state_t  : AR indirection FSM states
//                 (the FSM exists only when AR_INDIRECT_CHAIN_EN is defined)
// ---------------------------------------------------------------------------
package mano_pkg;

    localparam int unsigned D_AND = 0;
    localparam int unsigned D_ADD = 1;
    localparam int unsigned D_LDA = 2;
    localparam int unsigned D_STA = 3;
    localparam int unsigned D_BUN = 4;
    localparam int unsigned D_BSA = 5;
    localparam int unsigned D_ISZ = 6;
    localparam int unsigned D_RR  = 7;

    localparam int unsigned T0 = 0;
    localparam int unsigned T1 = 1;
    localparam int unsigned T2 = 2;
    localparam int unsigned T3 = 3;
    localparam int unsigned T4 = 4;
    localparam int unsigned T5 = 5;
    localparam int unsigned T6 = 6;
    localparam int unsigned T7 = 7;

    typedef enum logic {
        IDLE,
        IND
    } ar_state_t;

endpackage

// File: rtl/mano_ar_ctrl.sv
// ---------------------------------------------------------------------------
// mano_ar_ctrl
// Pure combinational decode of the AR control strobes.
//   T   in  NT  one-hot timing vector
//   D   in  8   one-hot opcode decode
//   I   in  1   indirect bit of the current instruction
//   R   in  1   interrupt-cycle flag
//   ld  out 1   R'T0 | R'T2 | D7'IT3
//   clr out 1   RT0
//   inc out 1   D5T4
// A non-one-hot T decodes literally; the register applies the priority.
// ---------------------------------------------------------------------------
module mano_ar_ctrl
    import mano_pkg::*;
#(
    parameter int NT = 8
) (
    input  logic [NT-1:0] T,
    input  logic [7:0]    D,
    input  logic          I,
    input  logic          R,
    output logic          ld,
    output logic          clr,
    output logic          inc
);

    logic unused_bits;

    always_comb begin
        ld  = (~R & T[T0]) | (~R & T[T2]) | (~D[D_RR] & I & T[T3]);
        clr = R & T[T0];
        inc = D[D_BSA] & T[T4];
    end

    // Only a few bits of D and T take part in the AR decode.
    assign unused_bits = ^{D, T};

endmodule

// File: rtl/mano_ar_unit.sv
// ---------------------------------------------------------------------------
// mano_ar_unit
// Address register (AR) of the Mano basic computer with its own control
// decode and optional multi-level indirection.
//   clk     in  1   rising-edge clock
//   rst     in  1   asynchronous, active-high reset
//   T       in  NT  one-hot timing vector
//   D       in  8   one-hot opcode decode
//   I       in  1   indirect bit of the current instruction
//   R       in  1   interrupt-cycle flag
//   bus_in  in  BW  common bus; bus_in[BW-1] is the indirect flag of a word
//   ar_q    out AW  AR contents (memory address)
//   ld      out 1   load strobe (combinational)
//   clr     out 1   clear strobe (combinational)
//   inc     out 1   increment strobe (combinational)
//   sc_hold out 1   freeze the sequence counter during chained indirection
//   ind_err out 1   sticky: indirection depth exceeded
// Configuration macro: AR_INDIRECT_CHAIN_EN
//   defined   : chained indirection up to MAX_IND loads via the IND state
//   undefined : single-level indirection; sc_hold and ind_err tied to 0
// ---------------------------------------------------------------------------
module mano_ar_unit
    import mano_pkg::*;
#(
    parameter int AW      = 12,
    parameter int BW      = 16,
    parameter int NT      = 8,
    parameter int MAX_IND = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [NT-1:0] T,
    input  logic [7:0]    D,
    input  logic          I,
    input  logic          R,
    input  logic [BW-1:0] bus_in,
    output logic [AW-1:0] ar_q,
    output logic          ld,
    output logic          clr,
    output logic          inc,
    output logic          sc_hold,
    output logic          ind_err
);

    generate
        if (MAX_IND < 1) begin : g_bad_max_ind
            $error("mano_ar_unit: MAX_IND must be at least 1");
        end
    endgenerate

    logic          in_ind;
    logic          ind_fetch;
    logic          ind_flag;
    logic          do_clr;
    logic          do_load;
    logic [AW-1:0] bus_word;
    logic          unused_bits;

    mano_ar_ctrl #(
        .NT (NT)
    ) u_ctrl (
        .T   (T),
        .D   (D),
        .I   (I),
        .R   (R),
        .ld  (ld),
        .clr (clr),
        .inc (inc)
    );

    assign ind_fetch = ~D[D_RR] & I & T[T3];
    assign ind_flag  = bus_in[BW-1];
    assign bus_word  = bus_in[AW-1:0];

    // Inside a chain every cycle reloads AR from the bus, and an interrupt
    // aborts the chain with AR cleared.
    assign do_clr  = clr | (in_ind & R);
    assign do_load = ld | in_ind;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ar_q <= '0;
        end else if (do_clr) begin
            ar_q <= '0;
        end else if (do_load) begin
            ar_q <= bus_word;
        end else if (inc) begin
            ar_q <= ar_q + AW'(1);
        end
    end

`ifdef AR_INDIRECT_CHAIN_EN
    localparam int DW = $clog2(MAX_IND + 1);

    ar_state_t     state;
    logic [DW-1:0] depth;
    logic [DW-1:0] depth_inc;
    logic          err_q;

    assign in_ind    = (state == IND);
    assign depth_inc = depth + DW'(1);

    // depth counts indirect loads of the current chain, including the load
    // that started it; the chain only begins if that load actually happened.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            depth <= '0;
            err_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!clr && ind_fetch && ind_flag) begin
                        if (MAX_IND <= 1) begin
                            err_q <= 1'b1;
                        end else begin
                            state <= IND;
                            depth <= DW'(1);
                        end
                    end
                end
                IND: begin
                    if (R || !ind_flag) begin
                        state <= IDLE;
                        depth <= '0;
                    end else if (depth_inc == DW'(MAX_IND)) begin
                        state <= IDLE;
                        depth <= '0;
                        err_q <= 1'b1;
                    end else begin
                        depth <= depth_inc;
                    end
                end
                default: begin
                    state <= IDLE;
                    depth <= '0;
                end
            endcase
        end
    end

    assign sc_hold = in_ind;
    assign ind_err = err_q;
`else
    assign in_ind  = 1'b0;
    assign sc_hold = 1'b0;
    assign ind_err = 1'b0;
`endif

    // Upper bus bits and most decode lines are not needed by this slice.
    assign unused_bits = ^{bus_in[BW-1:AW], D, T, ind_fetch, ind_flag};

endmodule

// File: tb/tb_mano_ar_unit.sv
module tb_mano_ar_unit;

    localparam int NT      = 8;
    localparam int MAX_IND = 4;
`ifdef AR_INDIRECT_CHAIN_EN
    localparam bit CHAIN = 1'b1;
`else
    localparam bit CHAIN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [NT-1:0] T;
    logic [7:0]    D;
    logic          I;
    logic          R;
    logic [15:0]   bus_in;
    logic [11:0]   ar_q;
    logic          ld, clr, inc, sc_hold, ind_err;

    int total = 0;
    int bad   = 0;

    // behavioural model state
    int m_ar    = 0;
    bit m_ind   = 1'b0;
    int m_depth = 0;
    bit m_err   = 1'b0;

    mano_ar_unit #(
        .AW      (12),
        .BW      (16),
        .NT      (NT),
        .MAX_IND (MAX_IND)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .T       (T),
        .D       (D),
        .I       (I),
        .R       (R),
        .bus_in  (bus_in),
        .ar_q    (ar_q),
        .ld      (ld),
        .clr     (clr),
        .inc     (inc),
        .sc_hold (sc_hold),
        .ind_err (ind_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit f_ld();
        return (!R && T[0]) || (!R && T[2]) || (!D[7] && I && T[3]);
    endfunction

    function automatic bit f_clr();
        return R && T[0];
    endfunction

    function automatic bit f_inc();
        return D[5] && T[4];
    endfunction

    task automatic model_reset();
        m_ar    = 0;
        m_ind   = 1'b0;
        m_depth = 0;
        m_err   = 1'b0;
    endtask

    task automatic model_adv();
        bit l;
        bit c;
        bit n;
        bit flag;
        int w;
        l    = f_ld();
        c    = f_clr();
        n    = f_inc();
        flag = bus_in[15];
        w    = int'(bus_in) % 4096;
        if (m_ind) begin
            if (R) begin
                m_ar = 0; m_ind = 1'b0; m_depth = 0;
            end else begin
                m_ar = w;
                m_depth = m_depth + 1;
                if (!flag) begin
                    m_ind = 1'b0; m_depth = 0;
                end else if (m_depth >= MAX_IND) begin
                    m_ind = 1'b0; m_depth = 0; m_err = 1'b1;
                end
            end
        end else begin
            if (c)      m_ar = 0;
            else if (l) m_ar = w;
            else if (n) m_ar = (m_ar + 1) % 4096;
            if (CHAIN && !c && !D[7] && I && T[3] && flag) begin
                if (MAX_IND <= 1) m_err = 1'b1;
                else begin
                    m_ind = 1'b1; m_depth = 1;
                end
            end
        end
    endtask

    // Single compare process: every negedge, outputs against the model.
    always @(negedge clk) begin
        check("ar_q",    32'(ar_q),    32'(m_ar));
        check("ld",      32'(ld),      32'(f_ld()));
        check("clr",     32'(clr),     32'(f_clr()));
        check("inc",     32'(inc),     32'(f_inc()));
        check("sc_hold", 32'(sc_hold), 32'(m_ind));
        check("ind_err", 32'(ind_err), 32'(m_err));
    end

    task automatic step();
        @(posedge clk);
        if (!rst) model_adv();
        #1;
    endtask

    task automatic set_in(input logic [NT-1:0] t, input logic [7:0] d,
                          input logic i, input logic r, input logic [15:0] b);
        T = t; D = d; I = i; R = r; bus_in = b;
    endtask

    task automatic pulse_reset();
        #1 rst = 1'b1;
        model_reset();
        #1 rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        set_in('0, 8'h01, 1'b0, 1'b0, 16'h0000);
        step();
        step();
        rst = 1'b0;
        step();

        // 1: async reset clears a loaded AR before any edge
        set_in(8'h01, 8'h01, 1'b0, 1'b0, 16'h05A5);
        step();
        check("t1_ar_loaded", 32'(ar_q), 32'h5A5);
        set_in('0, 8'h01, 1'b0, 1'b0, 16'h0000);
        #1 rst = 1'b1;
        model_reset();
        #1;
        check("t1_ar_async", 32'(ar_q), 32'h0);
        check("t1_err", 32'(ind_err), 32'h0);
        rst = 1'b0;
        step();

        // 2: R'T0 and R'T2 loads
        set_in(8'h01, 8'h01, 1'b0, 1'b0, 16'h0123);
        #1 check("t2_ld", 32'(ld), 32'h1);
        step();
        check("t2_ar_pc", 32'(ar_q), 32'h123);
        set_in(8'h04, 8'h01, 1'b0, 1'b0, 16'h8ABC);
        step();
        check("t2_ar_ir", 32'(ar_q), 32'hABC);

        // 3: increment wrap and interrupt clear at 0xFFF
        set_in(8'h01, 8'h01, 1'b0, 1'b0, 16'h0FFF);
        step();
        set_in(8'h10, 8'h20, 1'b0, 1'b0, 16'h1234);
        #1 check("t3_inc", 32'(inc), 32'h1);
        step();
        check("t3_wrap", 32'(ar_q), 32'h000);
        set_in(8'h01, 8'h01, 1'b0, 1'b0, 16'h0FFF);
        step();
        set_in(8'h01, 8'h01, 1'b0, 1'b1, 16'h0FFF);
        #1 check("t3_clr", 32'(clr), 32'h1);
        step();
        check("t3_cleared", 32'(ar_q), 32'h000);

        // 4: single indirect load
        set_in(8'h08, 8'h01, 1'b1, 1'b0, 16'h0040);
        step();
        check("t4_ar", 32'(ar_q), 32'h040);
        check("t4_hold", 32'(sc_hold), 32'h0);
        set_in('0, 8'h01, 1'b0, 1'b0, 16'h0000);
        step();

        // 5a: chain of three words, T3 held
        set_in(8'h08, 8'h01, 1'b1, 1'b0, 16'h8010);
        step();
        check("t5_hold1", 32'(sc_hold), 32'(CHAIN));
        bus_in = 16'h8020;
        step();
        check("t5_hold2", 32'(sc_hold), 32'(CHAIN));
        bus_in = 16'h0030;
        step();
        check("t5_hold3", 32'(sc_hold), 32'h0);
        check("t5_ar", 32'(ar_q), 32'h030);
        check("t5_err", 32'(ind_err), 32'h0);
        set_in('0, 8'h01, 1'b0, 1'b0, 16'h0000);
        step();

        // 5b: depth exceeded after four indirect loads
        set_in(8'h08, 8'h01, 1'b1, 1'b0, 16'h8111);
        step();
        bus_in = 16'h8222;
        step();
        bus_in = 16'h8333;
        step();
        check("t5b_hold3", 32'(sc_hold), 32'(CHAIN));
        bus_in = 16'h8444;
        step();
        check("t5b_hold4", 32'(sc_hold), 32'h0);
        check("t5b_err", 32'(ind_err), 32'(CHAIN));
        check("t5b_ar", 32'(ar_q), 32'h444);
        set_in('0, 8'h01, 1'b0, 1'b0, 16'h0000);
        step();

        // 6: reset mid-chain, then resume
        set_in(8'h08, 8'h01, 1'b1, 1'b0, 16'h8055);
        step();
        bus_in = 16'h8066;
        #1 rst = 1'b1;
        model_reset();
        #1;
        check("t6_hold_rst", 32'(sc_hold), 32'h0);
        check("t6_ar_rst", 32'(ar_q), 32'h0);
        check("t6_err_rst", 32'(ind_err), 32'h0);
        rst = 1'b0;
        step();
        check("t6_ar_resume", 32'(ar_q), 32'h066);
        check("t6_hold_resume", 32'(sc_hold), 32'(CHAIN));
        bus_in = 16'h0077;
        step();
        check("t6_ar_end", 32'(ar_q), 32'h077);
        check("t6_hold_end", 32'(sc_hold), 32'h0);

        // randomized phase
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                set_in(8'h08, 8'(1 << $urandom_range(0, 6)), 1'b1,
                       ($urandom_range(0, 15) == 0),
                       {($urandom_range(0, 3) != 0), 15'($urandom)});
            end else begin
                T = ($urandom_range(0, 7) == 0) ? 8'($urandom)
                                                 : 8'(1 << $urandom_range(0, 7));
                D = ($urandom_range(0, 7) == 0) ? 8'($urandom)
                                                 : 8'(1 << $urandom_range(0, 7));
                I = 1'($urandom);
                R = ($urandom_range(0, 5) == 0);
                bus_in = 16'($urandom);
            end
            if ($urandom_range(0, 199) == 0) pulse_reset();
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
